borrow_skip_subtractor: RTL and testbench



---
 rtl/borrow_skip_pkg.sv | 22 ++
 rtl/borrow_block.sv | 31 +++
 rtl/borrow_skip_subtractor.sv | 131 +++++++++++++
 tb/tb_borrow_skip_subtractor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/borrow_skip_pkg.sv
// Shared types and constants for the borrow-skip subtractor.
package borrow_skip_pkg;

  // Operation sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Default geometry: two 4-bit borrow-skip blocks.
  localparam int BSS_WIDTH = 8;
  localparam int BSS_BLOCK = 4;
  localparam int BSS_NBLK  = BSS_WIDTH / BSS_BLOCK;

  // Block index register width; it must also hold the value NBLK,
  // which marks "all blocks consumed".
  function automatic int idx_width(input int nblk);
    return $clog2(nblk + 1);
  endfunction

endpackage

// File: rtl/borrow_block.sv
// BLOCK-bit combinational ripple-borrow subtractor with a propagate flag.
// The flag is set when every operand bit pair is equal; such a block
// passes its borrow-in straight through and its difference bits all
// equal that borrow.
module borrow_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             bin,
  output logic [BLOCK-1:0] diff,
  output logic             bout,
  output logic             p
);

  logic [BLOCK:0] chain;

  // Ripple the borrow through the block bit by bit.
  always_comb begin
    chain    = '0;
    diff     = '0;
    chain[0] = bin;
    for (int i = 0; i < BLOCK; i++) begin
      diff[i]      = a[i] ^ b[i] ^ chain[i];
      chain[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
    end
    bout = chain[BLOCK];
    p    = &(~(a ^ b));
  end

endmodule

// File: rtl/borrow_skip_subtractor.sv
// Sequential subtractor: diff = a - b - bin, one skip group per cycle.
//
// Handshake: an operand transfer happens on a rising edge where
// in_valid && in_ready; a result transfer happens on a rising edge where
// out_valid && out_ready. in_ready is high only in IDLE and out_valid
// only in DONE, so operations never overlap and the result (diff,
// borrow_out) stays frozen for as long as the consumer stalls.
module borrow_skip_subtractor
  import borrow_skip_pkg::*;
#(
  parameter int WIDTH = BSS_WIDTH,
  parameter int BLOCK = BSS_BLOCK   // WIDTH must be a multiple of BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output state_t           dbg_state
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int IDXW = idx_width(NBLK);
  localparam logic [IDXW-1:0] K_END = IDXW'(NBLK);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic              br_q, br_d;
  logic [IDXW-1:0]   k_q, k_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q;

  logic [WIDTH-1:0]  blk_diff;
  logic [NBLK-1:0]   blk_bout;
  logic [NBLK-1:0]   blk_p;

  // Every block sees the running borrow as its borrow-in: inside a group
  // the leading propagate blocks pass it unchanged, so the closing
  // non-propagate block receives exactly that borrow too.
  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    borrow_block #(.BLOCK(BLOCK)) u_blk (
      .a    (a_q[g*BLOCK +: BLOCK]),
      .b    (b_q[g*BLOCK +: BLOCK]),
      .bin  (br_q),
      .diff (blk_diff[g*BLOCK +: BLOCK]),
      .bout (blk_bout[g]),
      .p    (blk_p[g])
    );
  end

  logic            found;
  logic [IDXW-1:0] sel;

  // Group select: find the first non-propagate block at or after k; the
  // group spans k..sel, or k..NBLK-1 when only propagate blocks remain.
  always_comb begin
    found  = 1'b0;
    sel    = '0;
    br_d   = br_q;
    diff_d = diff_q;
    for (int i = 0; i < NBLK; i++) begin
      if (!found && (IDXW'(i) >= k_q) && !blk_p[i]) begin
        found = 1'b1;
        sel   = IDXW'(i);
        br_d  = blk_bout[i];
      end
    end
    k_d = found ? (sel + IDXW'(1)) : K_END;
    for (int i = 0; i < NBLK; i++) begin
      if ((IDXW'(i) >= k_q) && (!found || (IDXW'(i) <= sel))) begin
        diff_d[i*BLOCK +: BLOCK] = blk_diff[i*BLOCK +: BLOCK];
      end
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: if (in_valid)       state_d = ST_RUN;
      ST_RUN:  if (k_d == K_END)   state_d = ST_DONE;
      ST_DONE: if (out_ready)      state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      k_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q  <= a;
            b_q  <= b;
            br_q <= bin;
            k_q  <= '0;
          end
        end
        ST_RUN: begin
          diff_q <= diff_d;
          br_q   <= br_d;
          k_q    <= k_d;
          if (k_d == K_END) bout_q <= br_d;
        end
        default: ;
      endcase
    end
  end

  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_borrow_skip_subtractor.sv
// Directed bench for borrow_skip_subtractor.
module tb_borrow_skip_subtractor;
  import borrow_skip_pkg::*;

  localparam int W = 8;

  // Clock / reset
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         borrow_out;
  state_t       dbg_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  borrow_skip_subtractor dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .bin        (bin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .dbg_state  (dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff got=%h exp=00", diff); end
    checks++;
    if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow got=%b exp=0", borrow_out); end
    checks++;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
  endtask

  // One full operation with immediate consumption; checks latency,
  // result, and the return to IDLE.
  task automatic run_op(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vbin, input logic [W-1:0] exp_d, input logic exp_b,
                        input int exp_n);
    int cnt;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_before got=%b exp=1", name, in_ready); end
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = ~va; b = 8'h5A; bin = ~vbin;   // must be ignored from here on
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 10) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt !== exp_n) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, cnt, exp_n); end
    checks++;
    if (diff !== exp_d) begin errors++; $display("FAIL %s_diff got=%h exp=%h", name, diff, exp_d); end
    checks++;
    if (borrow_out !== exp_b) begin errors++; $display("FAIL %s_borrow got=%b exp=%b", name, borrow_out, exp_b); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_ready_done got=%b exp=0", name, in_ready); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_release got valid=%b ready=%b exp valid=0 ready=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    run_op("sub_35_12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 2);
    run_op("sub_12_35", 8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 2);
    run_op("absorb_5c_3c", 8'h5C, 8'h3C, 1'b0, 8'h20, 1'b0, 1);
    run_op("allprop_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1);
    run_op("tail_53_52", 8'h53, 8'h52, 1'b0, 8'h01, 1'b0, 2);
    run_op("tail_50_51", 8'h50, 8'h51, 1'b0, 8'hFF, 1'b1, 2);
    run_op("bin_35_12", 8'h35, 8'h12, 1'b1, 8'h22, 1'b0, 2);
  endtask

  task automatic test_idle_out_ready();
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL idle_out_ready got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int cnt;
    a = 8'hA7; b = 8'h41; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 10) begin tick(); cnt++; end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got valid=%b exp=1", out_valid); end
    // A new offer while DONE must not be captured.
    a = 8'h01; b = 8'h02; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (diff !== 8'h66 || borrow_out !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d got diff=%h bo=%b v=%b r=%b exp diff=66 bo=0 v=1 r=0",
                 i, diff, borrow_out, out_valid, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    a = 8'h12; b = 8'h35; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (dbg_state !== ST_RUN) begin errors++; $display("FAIL rr_in_run got=%0d exp=%0d", dbg_state, ST_RUN); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || diff !== 8'h00 || in_ready !== 1'b1 || borrow_out !== 1'b0) begin
      errors++; $display("FAIL rr_after got v=%b diff=%h r=%b bo=%b exp v=0 diff=00 r=1 bo=0",
                         out_valid, diff, in_ready, borrow_out);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_no_result got=%b exp=0", out_valid); end
    run_op("rr_next", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 2);
  endtask

  task automatic test_back_to_back();
    int cnt;
    out_ready = 1'b1;
    a = 8'h5C; b = 8'h3C; bin = 1'b0; in_valid = 1'b1;
    tick();
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 10) begin tick(); cnt++; end
    checks++;
    if (diff !== 8'h20 || cnt !== 1) begin
      errors++; $display("FAIL b2b_first got diff=%h lat=%0d exp diff=20 lat=1", diff, cnt);
    end
    a = 8'h35; b = 8'h12;
    cnt = 0;
    tick();
    cnt++;
    while (out_valid !== 1'b1 && cnt < 12) begin tick(); cnt++; end
    in_valid = 1'b0;
    checks++;
    if (diff !== 8'h23 || borrow_out !== 1'b0) begin
      errors++; $display("FAIL b2b_second got diff=%h bo=%b exp diff=23 bo=0", diff, borrow_out);
    end
    checks++;
    if (cnt !== 4) begin errors++; $display("FAIL b2b_spacing got=%0d exp=4", cnt); end
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_end got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_out_ready();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
